// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready flow control and sum/cout/ovf/zero flags.
// Optional saturation on signed overflow: define CLA_ADDSUB_SAT_EN to add the sat input.
module cla_addsub_pipe #(
    parameter int WIDTH  = 32,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
`ifdef CLA_ADDSUB_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int G   = WIDTH / BLOCK;
    localparam int GPS = G / STAGES;
    localparam int SW  = GPS * BLOCK;

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    // Stage k loads when its valid bit is 0 or stage k+1 loads; out_ready stands in for
    // the stage after the last. in_ready never looks at in_valid.

    // Per-stage inputs: stage 0 is fed from the ports, stage k>0 from stage k-1's registers.
    logic [STAGES-1:0] vin;
    logic [STAGES-1:0] cin_s;
    logic [STAGES-1:0] vq;
    logic [STAGES:0]   ld;
    logic [WIDTH-1:0]  ain [STAGES];
    logic [WIDTH-1:0]  bin [STAGES];
    logic [WIDTH-1:0]  sin [STAGES];
`ifdef CLA_ADDSUB_SAT_EN
    logic [STAGES-1:0] satin;
    assign satin[0] = sat;
`endif

    assign vin[0]   = in_valid;
    assign ain[0]   = a;
    assign bin[0]   = op_sub ? ~b : b;
    assign sin[0]   = '0;
    assign cin_s[0] = op_sub | cin;

    always_comb begin
        ld         = '0;
        ld[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            ld[k] = ~vq[k] | ld[k+1];
        end
    end

    assign in_ready = ld[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SW-1:0]  op_a;
        logic [SW-1:0]  op_b;
        logic [SW-1:0]  p;
        logic [SW-1:0]  g;
        logic [SW-1:0]  slice;
        logic [GPS-1:0] grp_p;
        logic [GPS-1:0] grp_g;
        logic [GPS:0]   gc;
        logic           c_msb;

        // Group P/G, then every group carry expanded directly from the stage carry-in.
        always_comb begin
            logic term;
            logic acc;
            logic c;
            op_a  = ain[k][k*SW +: SW];
            op_b  = bin[k][k*SW +: SW];
            p     = op_a ^ op_b;
            g     = op_a & op_b;
            grp_p = '0;
            grp_g = '0;
            gc    = '0;
            slice = '0;
            c_msb = 1'b0;
            term  = 1'b0;
            acc   = 1'b0;
            c     = 1'b0;
            for (int j = 0; j < GPS; j++) begin
                grp_p[j] = &p[j*BLOCK +: BLOCK];
                acc = 1'b0;
                for (int i = 0; i < BLOCK; i++) begin
                    acc = g[j*BLOCK+i] | (p[j*BLOCK+i] & acc);
                end
                grp_g[j] = acc;
            end
            gc[0] = cin_s[k];
            for (int j = 1; j <= GPS; j++) begin
                term = cin_s[k];
                for (int m = 0; m < j; m++) term = term & grp_p[m];
                acc = term;
                for (int i = 0; i < j; i++) begin
                    term = grp_g[i];
                    for (int m = i + 1; m < j; m++) term = term & grp_p[m];
                    acc = acc | term;
                end
                gc[j] = acc;
            end
            for (int j = 0; j < GPS; j++) begin
                c = gc[j];
                for (int i = 0; i < BLOCK; i++) begin
                    c_msb = c;
                    slice[j*BLOCK+i] = p[j*BLOCK+i] ^ c;
                    c = g[j*BLOCK+i] | (p[j*BLOCK+i] & c);
                end
            end
        end

        if (k < STAGES - 1) begin : g_mid
            logic             vld_q;
            logic             c_q;
            logic [WIDTH-1:0] s_q;
            logic [WIDTH-1:0] s_d;
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;
`ifdef CLA_ADDSUB_SAT_EN
            logic             sat_q;
            assign satin[k+1] = sat_q;
`endif

            always_comb begin
                s_d = sin[k];
                s_d[k*SW +: SW] = slice;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= 1'b0;
                    c_q   <= 1'b0;
                    s_q   <= '0;
                    a_q   <= '0;
                    b_q   <= '0;
`ifdef CLA_ADDSUB_SAT_EN
                    sat_q <= 1'b0;
`endif
                end else if (ld[k]) begin
                    vld_q <= vin[k];
                    if (vin[k]) begin
                        c_q <= gc[GPS];
                        s_q <= s_d;
                        a_q <= ain[k];
                        b_q <= bin[k];
`ifdef CLA_ADDSUB_SAT_EN
                        sat_q <= satin[k];
`endif
                    end
                end
            end

            assign vq[k]      = vld_q;
            assign vin[k+1]   = vld_q;
            assign cin_s[k+1] = c_q;
            assign sin[k+1]   = s_q;
            assign ain[k+1]   = a_q;
            assign bin[k+1]   = b_q;
        end else begin : g_last
            logic [WIDTH-1:0] full_d;
            logic             ovf_d;
            logic             vld_q;
            logic [WIDTH-1:0] sum_q;
            logic             cout_q;
            logic             ovf_q;
            logic             zero_q;

            always_comb begin
                full_d = sin[k];
                full_d[k*SW +: SW] = slice;
                ovf_d = c_msb ^ gc[GPS];
`ifdef CLA_ADDSUB_SAT_EN
                if (satin[k] && ovf_d) begin
                    full_d = ain[k][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                             : {1'b0, {(WIDTH-1){1'b1}}};
                end
`endif
            end

            // Data only loads with a valid op so the outputs keep the last accepted result.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q  <= 1'b0;
                    sum_q  <= '0;
                    cout_q <= 1'b0;
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (ld[k]) begin
                    vld_q <= vin[k];
                    if (vin[k]) begin
                        sum_q  <= full_d;
                        cout_q <= gc[GPS];
                        ovf_q  <= ovf_d;
                        zero_q <= (full_d == '0);
                    end
                end
            end

            assign vq[k]     = vld_q;
            assign out_valid = vld_q;
            assign sum       = sum_q;
            assign cout      = cout_q;
            assign ovf       = ovf_q;
            assign zero      = zero_q;
        end
    end

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Directed bench for cla_addsub_pipe (WIDTH=32, BLOCK=4, STAGES=2): reset, latency,
// streaming, backpressure, random ready and mid-stream reset, with a FIFO scoreboard.
module tb_cla_addsub_pipe;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         op_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
`ifdef CLA_ADDSUB_SAT_EN
    logic         sat_in = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
    } stim_t;

    stim_t        stim_q[$];
    logic [W+2:0] exp_q[$];   // {sum, cout, ovf, zero}

    int n_checks   = 0;
    int n_errors   = 0;
    int cyc        = 0;
    int n_acc      = 0;
    int n_fire     = 0;
    int first_fire = -1;
    int last_fire  = -1;

    cla_addsub_pipe #(.WIDTH(W), .BLOCK(4), .STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .op_sub    (op_sub),
`ifdef CLA_ADDSUB_SAT_EN
        .sat       (sat_in),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic add_vec(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                           input logic vs, input logic [W-1:0] es, input logic [2:0] eflags);
        stim_t s;
        s.a   = va;
        s.b   = vb;
        s.cin = vc;
        s.sub = vs;
        stim_q.push_back(s);
        exp_q.push_back({es, eflags});
    endtask

    // Hand-computed vectors; flags are {cout, ovf, zero}.
    task automatic load_table();
        add_vec(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 3'b101);
        add_vec(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 3'b110);
        add_vec(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 3'b010);
        add_vec(32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 32'h0000_0004, 3'b000);
        add_vec(32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0000, 3'b101);
        add_vec(32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, 32'hFFFF_FFFE, 3'b000);
        add_vec(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 3'b000);
        add_vec(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 3'b111);
        add_vec(32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0001_0000, 3'b000);
        add_vec(32'h0000_0010, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_000F, 3'b100);
        add_vec(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'hFFFF_FFFF, 3'b000);
        add_vec(32'h0000_0FFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_1000, 3'b000);
    endtask

    // driver + monitor: one clock per call, inputs driven on the falling edge
    task automatic step(input logic ordy);
        stim_t        s;
        logic [W+2:0] e;
        @(negedge clk);
        cyc++;
        if (stim_q.size() > 0) begin
            s        = stim_q[0];
            in_valid = 1'b1;
            a        = s.a;
            b        = s.b;
            cin      = s.cin;
            op_sub   = s.sub;
        end else begin
            in_valid = 1'b0;
        end
        out_ready = ordy;
        #1;
        if (out_valid && out_ready) begin
            n_fire++;
            if (first_fire < 0) first_fire = cyc;
            last_fire = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_result", out_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("sum", sum, e[W+2:3]);
                check("flags", {cout, ovf, zero}, e[2:0]);
            end
        end
        if (in_valid && in_ready) begin
            void'(stim_q.pop_front());
            n_acc++;
        end
    endtask

    task automatic drain(input int max_cyc, input bit rnd);
        int n = 0;
        while ((stim_q.size() > 0 || exp_q.size() > 0) && n < max_cyc) begin
            step(rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            n++;
        end
        check("drain_complete", stim_q.size() + exp_q.size(), 0);
    endtask

    initial begin
        int base_fire;
        int base_acc;
        int lat;
        int stale;

        // reset
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        op_sub    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_sum", sum, 32'h0);
        check("rst_flags", {cout, ovf, zero}, 3'b000);
        check("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // latency of a single op: FFFFFFFF + 1
        @(negedge clk);
        a = 32'hFFFF_FFFF; b = 32'h1; cin = 1'b0; op_sub = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("lat_in_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        #1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            #1;
            lat++;
        end
        check("latency", lat, 2);
        check("lat_sum", sum, 32'h0);
        check("lat_flags", {cout, ovf, zero}, 3'b101);
        @(negedge clk);
        #1;
        check("lat_single_result", out_valid, 1'b0);

        // back-to-back stream with out_ready held high
        base_fire  = n_fire;
        first_fire = -1;
        load_table();
        drain(100, 1'b0);
        check("stream_count", n_fire - base_fire, 12);
        check("stream_throughput", last_fire - first_fire, 11);

        // backpressure: out_ready low for 5 cycles with input pending
        base_fire = n_fire;
        base_acc  = n_acc;
        add_vec(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 3'b000);
        load_table();
        for (int i = 0; i < 5; i++) begin
            step(1'b0);
            if (i == 2) check("bp_hold_sum_early", sum, exp_q[0][W+2:3]);
        end
        check("bp_accepts", n_acc - base_acc, 2);
        check("bp_in_ready", in_ready, 1'b0);
        check("bp_out_valid", out_valid, 1'b1);
        check("bp_hold_sum_late", sum, exp_q[0][W+2:3]);
        drain(100, 1'b0);
        check("bp_count", n_fire - base_fire, 13);

        // stream with random out_ready
        base_fire = n_fire;
        load_table();
        drain(300, 1'b1);
        check("rnd_count", n_fire - base_fire, 12);

        // reset in the middle of a stalled stream
        load_table();
        repeat (3) step(1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_sum", sum, 32'h0);
        check("midrst_flags", {cout, ovf, zero}, 3'b000);
        stim_q.delete();
        exp_q.delete();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (out_valid) stale++;
        end
        check("midrst_no_stale", stale, 0);

        // still functional after reset
        base_fire = n_fire;
        add_vec(32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, 32'hFFFF_FFFE, 3'b000);
        add_vec(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 3'b010);
        drain(20, 1'b0);
        check("post_rst_count", n_fire - base_fire, 2);

        // report
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
